// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer and its bus interface.
package tone_seq_pkg;

   localparam int unsigned SeqDepth   = 16;
   localparam int unsigned SeqScaleW  = 6;
   localparam int unsigned SeqDurW    = 16;
   localparam int unsigned SeqTickDiv = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StPlay
   } seq_state_e;

   typedef struct packed {
      logic [SeqScaleW-1:0] scale;
      logic [SeqDurW-1:0]   dur;
   } entry_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Control, table-write and generator-facing signals of the tone sequencer.
interface tone_sequencer_if import tone_seq_pkg::*; #(
   parameter int unsigned DEPTH   = SeqDepth,
   parameter int unsigned SCALE_W = SeqScaleW,
   parameter int unsigned DUR_W   = SeqDurW
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [SCALE_W-1:0] wr_scale;
   logic [DUR_W-1:0]   wr_dur;
   logic [AW:0]        length;
   logic               loop_en;
   logic               start;
   logic               stop;
   logic [SCALE_W-1:0] scale_out;
   logic               tone_en;
   logic [AW-1:0]      step_idx;
   logic               busy;
   logic               done;

   modport master (
      output wr_en, wr_addr, wr_scale, wr_dur, length, loop_en, start, stop,
      input  scale_out, tone_en, step_idx, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_scale, wr_dur, length, loop_en, start, stop,
      output scale_out, tone_en, step_idx, busy, done
   );

endinterface

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV counter with synchronous clear; tick marks the wrap cycle.
module tick_prescaler import tone_seq_pkg::*; #(
   parameter int unsigned TICK_DIV = SeqTickDiv
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clr,
   output logic tick
);
   localparam int unsigned CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = !clr && (cnt_q == CW'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a programmed table of (scale, duration) entries into the square-wave generator,
// one LOAD cycle per entry followed by dur*TICK_DIV PLAY cycles, optionally looping.
module tone_sequencer import tone_seq_pkg::*; #(
   parameter int unsigned DEPTH    = SeqDepth,
   parameter int unsigned SCALE_W  = SeqScaleW,
   parameter int unsigned DUR_W    = SeqDurW,
   parameter int unsigned TICK_DIV = SeqTickDiv
) (
   input logic             sysclk,
   input logic             reset,
   tone_sequencer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   seq_state_e         state_q, state_d;
   logic [LW-1:0]      len_q, len_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [SCALE_W-1:0] cur_scale_q, cur_scale_d;
   logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;
   logic [DUR_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic               done_q, done_d;
   logic               tick, entry_end, last_entry;
   entry_t             tbl_q [DEPTH];
   entry_t             rd_entry;

   // Table has no reset; a LOAD colliding with a write sees the pre-write entry.
   always_ff @(posedge sysclk) begin
      if (bus.wr_en) begin
         tbl_q[bus.wr_addr] <= '{scale: bus.wr_scale, dur: bus.wr_dur};
      end
   end

   assign rd_entry = tbl_q[idx_q];

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .sysclk(sysclk),
      .reset (reset),
      .clr   (state_q != StPlay),
      .tick  (tick)
   );

   assign entry_end  = tick && (tick_cnt_q == cur_dur_q - DUR_W'(1));
   assign last_entry = (LW'(idx_q) + LW'(1)) >= len_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      cur_scale_d = cur_scale_q;
      cur_dur_d   = cur_dur_q;
      tick_cnt_d  = tick_cnt_q;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Cleared so the first LOAD of a run holds a silent output.
            cur_scale_d = '0;
            if (bus.start && !bus.stop && (bus.length != '0)) begin
               len_d   = (bus.length > LW'(DEPTH)) ? LW'(DEPTH) : bus.length;
               idx_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cur_scale_d = rd_entry.scale;
            cur_dur_d   = (rd_entry.dur == '0) ? DUR_W'(1) : rd_entry.dur;
            tick_cnt_d  = '0;
            state_d     = StPlay;
         end
         StPlay: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + DUR_W'(1);
            end
            if (entry_end) begin
               if (!last_entry) begin
                  idx_d   = idx_q + AW'(1);
                  state_d = StLoad;
               end else if (bus.loop_en) begin
                  idx_d   = '0;
                  state_d = StLoad;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (bus.stop) begin
         state_d = StIdle;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q     <= StIdle;
         len_q       <= '0;
         idx_q       <= '0;
         cur_scale_q <= '0;
         cur_dur_q   <= '0;
         tick_cnt_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         cur_scale_q <= cur_scale_d;
         cur_dur_q   <= cur_dur_d;
         tick_cnt_q  <= tick_cnt_d;
         done_q      <= done_d;
      end
   end

   // During LOAD cur_scale_q still carries the previous note, so the output never glitches.
   always_comb begin
      bus.scale_out = '0;
      bus.tone_en   = 1'b0;
      bus.step_idx  = '0;
      if (state_q != StIdle) begin
         bus.scale_out = cur_scale_q;
         bus.tone_en   = (cur_scale_q != '0);
         bus.step_idx  = idx_q;
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: per-cycle expected traces built from the melody table.
module tb_tone_sequencer;
   import tone_seq_pkg::*;

   localparam int unsigned Depth   = 16;
   localparam int unsigned TickDiv = 4;

   typedef struct packed {
      logic       busy;
      logic [5:0] scale;
      logic       ten;
      logic       done;
      logic       idx_chk;
      logic [3:0] idx;
   } samp_t;

   logic sysclk = 1'b0;
   logic reset  = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   samp_t      exp_q[$];
   logic [5:0] ref_scale [Depth];
   int         ref_dur   [Depth];
   logic [5:0] prev_s;

   always #5 sysclk = ~sysclk;

   tone_sequencer_if #(.DEPTH(Depth), .SCALE_W(6), .DUR_W(16)) bus ();

   tone_sequencer #(
      .DEPTH   (Depth),
      .SCALE_W (6),
      .DUR_W   (16),
      .TICK_DIV(TickDiv)
   ) dut (
      .sysclk(sysclk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   function automatic samp_t mk(logic b, logic [5:0] s, logic d, logic c, int i);
      samp_t r;
      r.busy = b; r.scale = s; r.ten = (s != 6'd0); r.done = d; r.idx_chk = c; r.idx = 4'(i);
      return r;
   endfunction

   // One pass over entries 0..len-1: a LOAD cycle holding the previous note, then the note.
   function automatic void add_pass(int len);
      for (int i = 0; i < len; i++) begin
         int d = (ref_dur[i] == 0) ? 1 : ref_dur[i];
         exp_q.push_back(mk(1'b1, prev_s, 1'b0, 1'b0, 0));
         for (int k = 0; k < d * TickDiv; k++) exp_q.push_back(mk(1'b1, ref_scale[i], 1'b0, 1'b1, i));
         prev_s = ref_scale[i];
      end
   endfunction

   function automatic void add_finish();
      exp_q.push_back(mk(1'b0, 6'd0, 1'b1, 1'b1, 0));
      exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b1, 0));
   endfunction

   function automatic void new_trace();
      exp_q.delete();
      prev_s = 6'd0;
   endfunction

   function automatic samp_t observe(samp_t e);
      samp_t o;
      o.busy = bus.busy; o.scale = bus.scale_out; o.ten = bus.tone_en; o.done = bus.done;
      o.idx_chk = e.idx_chk;
      o.idx = e.idx_chk ? bus.step_idx : e.idx;
      return o;
   endfunction

   task automatic wr_entry(int a, logic [5:0] s, int d);
      @(negedge sysclk);
      bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_scale = s; bus.wr_dur = 16'(d);
      @(negedge sysclk);
      bus.wr_en = 1'b0;
      ref_scale[a] = s;
      ref_dur[a] = d;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      samp_t o, e;
      e = mk(1'b0, 6'd0, 1'b0, 1'b1, 0);
      reset = 1'b1;
      repeat (3) @(negedge sysclk);
      for (int j = 0; j < 2; j++) begin
         o = observe(e); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL reset[%0d] got %p want %p", j, o, e);
         end
         reset = 1'b0;
         @(negedge sysclk);
      end
   endtask

   task automatic test_basic();
      samp_t o;
      wr_entry(0, 6'd10, 2);
      wr_entry(1, 6'd20, 1);
      new_trace(); add_pass(2); add_finish();
      bus.length = 5'd2; bus.loop_en = 1'b0; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) bus.start = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL basic[%0d] got %p want %p", j, o, exp_q[j]);
         end
      end
   endtask

   task automatic test_loop();
      samp_t o;
      int clr_at;
      new_trace(); add_pass(2); add_pass(2); add_finish();
      clr_at = exp_q.size() - 2 - ((ref_dur[1] == 0) ? 1 : ref_dur[1]) * TickDiv;
      bus.length = 5'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) bus.start = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL loop[%0d] got %p want %p", j, o, exp_q[j]);
         end
         if (j == clr_at) bus.loop_en = 1'b0;
      end
   endtask

   task automatic test_write_collision();
      samp_t o;
      int clr_at;
      wr_entry(0, 6'd10, 1);
      wr_entry(1, 6'd20, 1);
      new_trace(); add_pass(2);
      ref_scale[0] = 6'd30;   // new value only visible from the second pass
      add_pass(2); add_finish();
      clr_at = exp_q.size() - 2 - TickDiv;
      bus.length = 5'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) begin
            bus.start = 1'b0;
            bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_scale = 6'd30; bus.wr_dur = 16'd1;
         end
         if (j == 1) bus.wr_en = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL collision[%0d] got %p want %p", j, o, exp_q[j]);
         end
         if (j == clr_at) bus.loop_en = 1'b0;
      end
   endtask

   task automatic test_rest_zero_dur();
      samp_t o;
      wr_entry(0, 6'd0, 3);
      wr_entry(1, 6'd5, 0);
      new_trace(); add_pass(2); add_finish();
      bus.length = 5'd2; bus.loop_en = 1'b0; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) bus.start = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL rest_dur0[%0d] got %p want %p", j, o, exp_q[j]);
         end
      end
   endtask

   task automatic test_stop();
      samp_t o;
      wr_entry(0, 6'd10, 2);
      wr_entry(1, 6'd20, 1);
      new_trace(); add_pass(2);
      exp_q = exp_q[0:5];
      repeat (4) exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b1, 0));
      bus.length = 5'd2; bus.loop_en = 1'b0; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) bus.start = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL stop[%0d] got %p want %p", j, o, exp_q[j]);
         end
         if (j == 5) begin bus.stop = 1'b1; bus.start = 1'b1; end
         if (j == 8) begin bus.stop = 1'b0; bus.start = 1'b0; end
      end
   endtask

   task automatic test_length_zero();
      samp_t o, e;
      e = mk(1'b0, 6'd0, 1'b0, 1'b1, 0);
      bus.length = 5'd0; bus.start = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge sysclk);
         o = observe(e); vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL len0[%0d] got %p want %p", j, o, e);
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_random();
      samp_t o;
      int len;
      for (int it = 0; it < 3; it++) begin
         for (int a = 0; a < Depth; a++) wr_entry(a, 6'($urandom_range(0, 63)), $urandom_range(0, 2));
         len = (it == 0) ? 31 : $urandom_range(1, 20);
         new_trace(); add_pass((len > Depth) ? Depth : len); add_finish();
         bus.length = 5'(len); bus.loop_en = 1'b0; bus.start = 1'b1;
         foreach (exp_q[j]) begin
            @(negedge sysclk);
            if (j == 0) bus.start = 1'b0;
            o = observe(exp_q[j]); vectors++;
            if (o !== exp_q[j]) begin
               miscompares++;
               $display("FAIL random%0d_len%0d[%0d] got %p want %p", it, len, j, o, exp_q[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_play();
      samp_t o;
      wr_entry(0, 6'd10, 2);
      wr_entry(1, 6'd20, 1);
      new_trace(); add_pass(2);
      exp_q = exp_q[0:6];
      repeat (2) exp_q.push_back(mk(1'b0, 6'd0, 1'b0, 1'b1, 0));
      bus.length = 5'd2; bus.loop_en = 1'b1; bus.start = 1'b1;
      foreach (exp_q[j]) begin
         @(negedge sysclk);
         if (j == 0) bus.start = 1'b0;
         o = observe(exp_q[j]); vectors++;
         if (o !== exp_q[j]) begin
            miscompares++;
            $display("FAIL reset_mid[%0d] got %p want %p", j, o, exp_q[j]);
         end
         if (j == 6) reset = 1'b1;
         if (j == 7) reset = 1'b0;
      end
      bus.loop_en = 1'b0;
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_scale = '0; bus.wr_dur = '0;
      bus.length = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      test_reset();
      test_basic();
      test_loop();
      test_write_collision();
      test_rest_zero_dur();
      test_stop();
      test_length_zero();
      test_random();
      test_reset_mid_play();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
